tag_stream_writer: RTL and testbench
====================================

TAG_STREAM_WRITER -- requirements
Module: tag_stream_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data words.
REQ-002 SHALL have parameter TAG_WIDTH, default 8, width of assigned tags.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 16, maximum written-but-unreleased words (range 1..2^TAG_WIDTH).
REQ-004 SHALL have parameter TAG_INIT, default 0, first tag issued after reset or flush.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: clk, input, 1, rising-edge clock.
REQ-007 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports: s_valid (in, 1), s_data (in, DATA_WIDTH), s_ready (out, 1); upstream valid/ready stream.
REQ-009 SHALL have ports: m_wr_en (out, 1), m_wr_data (out, DATA_WIDTH), m_wr_tag (out, TAG_WIDTH), m_wr_ready (in, 1); tagged write into downstream cache FIFO.
REQ-010 SHALL have ports: tag_valid (out, 1), tag_out (out, TAG_WIDTH); reports the tag assigned to each write to the producer.
REQ-011 SHALL have ports: rel_en (in, 1), releases one outstanding credit when consumer retires a tag.
REQ-012 SHALL have ports: flush (in, 1), drain and restart tag sequence.
REQ-013 SHALL have ports: outstanding (out, $clog2(MAX_OUTSTANDING)+1), stall (out, 1), busy (out, 1).

Function
REQ-014 SHALL buffer input in a 2-entry in-order skid buffer; s_ready = (entries < 2) && state==RUN, derived from registers only.
REQ-015 SHALL accept a beat when s_valid && s_ready; accepted beat is eligible for write no earlier than the next cycle (min latency 1).
REQ-016 SHALL drive m_wr_en = (entries > 0) && m_wr_ready && (outstanding < MAX_OUTSTANDING), with m_wr_data = oldest entry, m_wr_tag = tag counter.
REQ-017 SHALL assert tag_valid = m_wr_en and tag_out = m_wr_tag in the same cycle.
REQ-018 SHALL on each write pop the oldest entry and increment tag counter modulo 2^TAG_WIDTH (wrap 2^TAG_WIDTH-1 -> 0).
REQ-019 SHALL update outstanding: +1 on write only, -1 on rel_en only (when >0), unchanged on both; rel_en at 0 ignored.
REQ-020 SHALL NOT let a same-cycle rel_en unblock a write when outstanding == MAX_OUTSTANDING.
REQ-021 SHALL support simultaneous accept and write; entry count unchanged, order preserved.
REQ-022 SHALL assert stall = (entries > 0) && !m_wr_en.
REQ-023 SHALL implement FSM RUN/DRAIN: RUN->DRAIN on flush; DRAIN holds s_ready low, continues writing buffered entries; DRAIN->RUN when entries == 0, loading tag counter with TAG_INIT on that transition.
REQ-024 SHALL ignore flush while in DRAIN; flush in RUN with empty buffer spends exactly one cycle in DRAIN.
REQ-025 SHALL assert busy = (state==DRAIN) || (entries > 0).

Reset
REQ-026 SHALL on rst: state RUN, entries 0, tag counter TAG_INIT, outstanding 0; hence s_ready 1, m_wr_en 0, tag_valid 0, stall 0, busy 0.
REQ-027 SHALL discard buffered entries on rst asserted mid-operation; rst overrides flush, rel_en and writes in the same cycle.

Configuration
REQ-028 SHALL, with macro TAG_STREAM_WRITER_STATS_EN defined, add outputs words_written[31:0] (+1 per write) and stall_cycles[31:0] (+1 per stall cycle), both saturating at 2^32-1 and cleared by rst.
REQ-029 SHALL, without TAG_STREAM_WRITER_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-030 SHALL cover: m_wr_ready=1, 3 beats 0xA,0xB,0xC back-to-back -> writes with tags 0,1,2 on cycles 1,2,3 after first accept, tag_valid each.
REQ-031 SHALL cover: m_wr_ready=0, 3 beats offered -> 2 accepted, s_ready 0, stall 1; m_wr_ready=1 -> 0xA then 0xB written in order, then third accepted.
REQ-032 SHALL cover: MAX_OUTSTANDING=2, no rel_en, 4 beats -> 2 writes, outstanding 2, stall 1; one rel_en -> exactly one more write next cycle.
REQ-033 SHALL cover: TAG_WIDTH=2, 6 writes with rel_en each cycle -> tags 0,1,2,3,0,1.
REQ-034 SHALL cover: 2 entries buffered, flush pulse -> s_ready 0, both written, tag counter back to TAG_INIT, RUN next cycle.
REQ-035 SHALL cover: rst asserted with 2 buffered entries and outstanding 5 -> next cycle entries 0, outstanding 0, no write issued.

Source files
------------

// File: rtl/tag_stream_writer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tag_stream_writer: skid-buffered stream to tagged cache-FIFO writer with   |
// | credit-limited outstanding count and flush/drain tag restart.             |
// | Optional stats outputs under TAG_STREAM_WRITER_STATS_EN. Revision: 1.0    |
// +---------------------------------------------------------------------------+
module tag_stream_writer #(
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_INIT        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  input  logic [DATA_WIDTH-1:0]                s_data,
  output logic                                 s_ready,
  output logic                                 m_wr_en,
  output logic [DATA_WIDTH-1:0]                m_wr_data,
  output logic [TAG_WIDTH-1:0]                 m_wr_tag,
  input  logic                                 m_wr_ready,
  output logic                                 tag_valid,
  output logic [TAG_WIDTH-1:0]                 tag_out,
  input  logic                                 rel_en,
  input  logic                                 flush,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 stall,
  output logic                                 busy
`ifdef TAG_STREAM_WRITER_STATS_EN
  ,
  output logic [31:0]                          words_written,
  output logic [31:0]                          stall_cycles
`endif
);

  localparam int                 OW      = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]      MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [TAG_WIDTH-1:0] TAG_RST = TAG_WIDTH'(TAG_INIT);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             entries;
  logic [DATA_WIDTH-1:0]  buf0;
  logic [DATA_WIDTH-1:0]  buf1;
  logic [TAG_WIDTH-1:0]   tag_cnt;
  logic                   wr;
  logic                   accept;
  logic                   rel_eff;
  logic                   drain_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    wr         = 1'b0;
    accept     = 1'b0;
    rel_eff    = 1'b0;
    drain_done = 1'b0;
    m_wr_en    = 1'b0;
    m_wr_data  = buf0;
    m_wr_tag   = tag_cnt;
    tag_valid  = 1'b0;
    tag_out    = tag_cnt;
    stall      = 1'b0;
    busy       = 1'b0;

    // s_ready is a pure function of registers so upstream never sees a comb loop
    s_ready    = (entries < 2'd2) && (state == RUN);
    wr         = (entries != 2'd0) && m_wr_ready && (outstanding < MAX_OUT);
    accept     = s_valid && s_ready;
    rel_eff    = rel_en && (outstanding != '0);
    drain_done = (state == DRAIN) && (entries == 2'd0);

    m_wr_en    = wr;
    tag_valid  = wr;
    stall      = (entries != 2'd0) && !wr;
    busy       = (state == DRAIN) || (entries != 2'd0);

    case (state)
      RUN:     if (flush)      state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries     <= 2'd0;
      tag_cnt     <= TAG_RST;
      outstanding <= '0;
    end else begin
      case ({accept, wr})
        2'b10:   entries <= entries + 2'd1;
        2'b01:   entries <= entries - 2'd1;
        default: entries <= entries;
      endcase

      // drain_done implies an empty buffer, so it never coincides with a write
      if (drain_done) begin
        tag_cnt <= TAG_RST;
      end else if (wr) begin
        tag_cnt <= tag_cnt + TAG_WIDTH'(1);
      end

      if (wr && !rel_eff) begin
        outstanding <= outstanding + OW'(1);
      end else if (!wr && rel_eff) begin
        outstanding <= outstanding - OW'(1);
      end
    end
  end

  // Data registers need no reset: entries alone decides what is valid
  always_ff @(posedge clk) begin
    if (wr) begin
      buf0 <= (entries == 2'd2) ? buf1 : s_data;
    end else if (accept && (entries == 2'd0)) begin
      buf0 <= s_data;
    end
    if (accept && !wr && (entries == 2'd1)) begin
      buf1 <= s_data;
    end
  end

`ifdef TAG_STREAM_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      if (wr && (words_written != 32'hFFFF_FFFF)) begin
        words_written <= words_written + 32'd1;
      end
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_stream_writer.sv
`default_nettype none
// Randomised and directed bench for tag_stream_writer against a queue-based model.
module tb_tag_stream_writer;

  localparam int DW    = 16;
  localparam int TW    = 3;
  localparam int MAXO  = 6;
  localparam int TINIT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic [DW-1:0]  s_data;
  logic           s_ready;
  logic           m_wr_en;
  logic [DW-1:0]  m_wr_data;
  logic [TW-1:0]  m_wr_tag;
  logic           m_wr_ready;
  logic           tag_valid;
  logic [TW-1:0]  tag_out;
  logic           rel_en;
  logic           flush;
  logic [3:0]     outstanding;
  logic           stall;
  logic           busy;

  tag_stream_writer #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO), .TAG_INIT(TINIT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_wr_en(m_wr_en), .m_wr_data(m_wr_data), .m_wr_tag(m_wr_tag),
    .m_wr_ready(m_wr_ready),
    .tag_valid(tag_valid), .tag_out(tag_out),
    .rel_en(rel_en), .flush(flush),
    .outstanding(outstanding), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, tag counter, credit count, drain flag
  logic [DW-1:0] q[$];
  int            tag_m;
  int            out_m;
  bit            drain_m;
  logic [DW-1:0] next_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit sv, input bit rdy, input bit rel, input bit fl, input bit rs);
    int n;
    bit e_srdy;
    bit e_wr;
    bit rel_ok;
    @(negedge clk);
    s_valid    = sv;
    s_data     = next_data;
    m_wr_ready = rdy;
    rel_en     = rel;
    flush      = fl;
    rst        = rs;
    #1;
    n      = q.size();
    e_srdy = (n < 2) && !drain_m;
    e_wr   = (n > 0) && rdy && (out_m < MAXO);
    rel_ok = rel && (out_m > 0);
    chk("s_ready", 32'(s_ready), 32'(e_srdy));
    chk("m_wr_en", 32'(m_wr_en), 32'(e_wr));
    chk("tag_valid", 32'(tag_valid), 32'(e_wr));
    chk("stall", 32'(stall), 32'((n > 0) && !e_wr));
    chk("busy", 32'(busy), 32'(drain_m || (n > 0)));
    chk("outstanding", 32'(outstanding), 32'(out_m));
    if (e_wr) begin
      chk("m_wr_data", 32'(m_wr_data), 32'(q[0]));
      chk("m_wr_tag", 32'(m_wr_tag), 32'(tag_m));
      chk("tag_out", 32'(tag_out), 32'(tag_m));
    end
    if (rs) begin
      q.delete();
      tag_m   = TINIT;
      out_m   = 0;
      drain_m = 0;
    end else begin
      if (drain_m && n == 0) begin
        drain_m = 0;
        tag_m   = TINIT;
      end else begin
        if (e_wr) tag_m = (tag_m + 1) % (1 << TW);
        if (!drain_m && fl) drain_m = 1;
      end
      if (e_wr) void'(q.pop_front());
      if (sv && e_srdy) begin
        q.push_back(next_data);
        next_data = DW'($urandom);
      end
      if (e_wr && !rel_ok) out_m++;
      else if (!e_wr && rel_ok) out_m--;
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_wr_ready = 1'b0;
    rel_en = 1'b0; flush = 1'b0;
    q.delete(); tag_m = TINIT; out_m = 0; drain_m = 0;
    repeat (2) @(negedge clk);
    step(0, 0, 0, 0, 1);
    // reset state
    step(0, 1, 0, 0, 0);

    // back-to-back beats with downstream ready
    next_data = 16'h000A;
    step(1, 1, 0, 0, 0);
    next_data = 16'h000B;
    step(1, 1, 0, 0, 0);
    next_data = 16'h000C;
    step(1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // downstream blocked: buffer fills, then drains in order
    repeat (4) step(1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // credit exhaustion then single release
    repeat (10) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0);

    // tag wrap with continuous release
    repeat (12) step(1, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);

    // flush with two buffered entries
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    repeat (5) step(1, 1, 1, 0, 0);
    // flush with empty buffer
    step(0, 1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0, 0);

    // reset with buffered entries and credits outstanding
    repeat (5) step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    repeat (3) step(0, 1, 0, 0, 0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 2) == 0,
           ($urandom % 16) == 0, ($urandom % 128) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
